// File: rtl/drive_input_ctrl_if.sv
// Signal bundle between the drive front end (slave) and the board/engine side (master).
// Keys, tick and engine feedback flow into the front end; conditioned controls flow out.
interface drive_input_ctrl_if;
  logic       tick_10hz;
  logic       key_throttle;
  logic       key_brake;
  logic       key_up;
  logic       key_down;
  logic [8:0] speed_kmh;
  logic       overload;
  logic       throttle;
  logic       brake;
  logic [2:0] gear;
  logic       shifting;
  logic       shift_denied;

  modport master (
    output tick_10hz, key_throttle, key_brake, key_up, key_down, speed_kmh, overload,
    input  throttle, brake, gear, shifting, shift_denied
  );

  modport slave (
    input  tick_10hz, key_throttle, key_brake, key_up, key_down, speed_kmh, overload,
    output throttle, brake, gear, shifting, shift_denied
  );
endinterface

// File: rtl/drive_input_ctrl.sv
// Key conditioning (2-FF sync + debounce) and gear-shift state machine feeding engine_model.
// Owns the current gear, enforces the clutch interval and blocks over-revving downshifts.
module drive_input_ctrl #(
  parameter int unsigned DEBOUNCE_CNT = 50000,
  parameter int unsigned SHIFT_TICKS  = 3,
  parameter int unsigned MAX_GEAR     = 6
) (
  input  logic              clk,
  input  logic              rst,
  drive_input_ctrl_if.slave bus
);

  localparam int KEY_N  = 4;
  localparam int K_THR  = 0;
  localparam int K_BRK  = 1;
  localparam int K_UP   = 2;
  localparam int K_DN   = 3;
  localparam int CNT_W  = 16;
  localparam int TICK_W = 16;

  localparam logic [CNT_W-1:0]  DB_LAST    = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [TICK_W-1:0] SHIFT_LOAD = TICK_W'(SHIFT_TICKS);
  localparam logic [2:0]        GEAR_TOP   = 3'(MAX_GEAR);

  typedef enum logic {
    READY = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Highest speed at which the engine may drop into the target gear; neutral is unlimited.
  function automatic logic over_rev(input logic [2:0] target, input logic [8:0] spd);
    logic [8:0] limit;
    case (target)
      3'd1:    limit = 9'd55;
      3'd2:    limit = 9'd95;
      3'd3:    limit = 9'd150;
      3'd4:    limit = 9'd210;
      3'd5:    limit = 9'd255;
      default: limit = 9'd511;
    endcase
    return spd > limit;
  endfunction

  logic [KEY_N-1:0] key_raw;
  logic [KEY_N-1:0] sync1_q, sync1_d;
  logic [KEY_N-1:0] sync2_q, sync2_d;
  logic [KEY_N-1:0] db_q, db_d;
  logic [KEY_N-1:0] db_prev_q, db_prev_d;
  logic [CNT_W-1:0] db_cnt_q [KEY_N];
  logic [CNT_W-1:0] db_cnt_d [KEY_N];

  state_e            state_q, state_d;
  logic [2:0]        gear_q, gear_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              denied_q, denied_d;
  logic              throttle_q, throttle_d;
  logic              brake_q, brake_d;

  logic       up_req;
  logic       down_req;
  logic       shifting;
  logic [2:0] target;

  assign key_raw  = {bus.key_down, bus.key_up, bus.key_brake, bus.key_throttle};
  assign up_req   = db_q[K_UP] & ~db_prev_q[K_UP];
  assign down_req = db_q[K_DN] & ~db_prev_q[K_DN];
  assign shifting = (state_q == SHIFT);
  assign target   = gear_q - 3'd1;

  // Synchroniser chain and edge-detect history
  always_comb begin
    sync1_d   = key_raw;
    sync2_d   = sync1_q;
    db_prev_d = db_q;
  end

  // Debounce: a key must disagree with its debounced level for DEBOUNCE_CNT
  // consecutive clocks before the level follows; any agreement restarts the count.
  always_comb begin
    db_d = db_q;
    for (int k = 0; k < KEY_N; k++) begin
      db_cnt_d[k] = '0;
      if (sync2_q[k] != db_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          db_d[k] = sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  // Shift FSM
  always_comb begin
    state_d    = state_q;
    gear_d     = gear_q;
    tick_cnt_d = tick_cnt_q;
    denied_d   = 1'b0;
    case (state_q)
      READY: begin
        if (up_req && down_req) begin
          denied_d = 1'b1;
        end else if (up_req) begin
          if (gear_q >= GEAR_TOP) begin
            denied_d = 1'b1;
          end else begin
            gear_d     = gear_q + 3'd1;
            state_d    = SHIFT;
            tick_cnt_d = SHIFT_LOAD;
          end
        end else if (down_req) begin
          if (gear_q == 3'd0 || over_rev(target, bus.speed_kmh)) begin
            denied_d = 1'b1;
          end else begin
            gear_d     = target;
            state_d    = SHIFT;
            tick_cnt_d = SHIFT_LOAD;
          end
        end
      end
      SHIFT: begin
        // Requests arriving while the clutch is open are dropped, never queued.
        if (up_req || down_req) begin
          denied_d = 1'b1;
        end
        if (tick_cnt_q == '0) begin
          state_d = READY;
        end else if (bus.tick_10hz) begin
          tick_cnt_d = tick_cnt_q - TICK_W'(1);
        end
      end
      default: state_d = READY;
    endcase
  end

  // Output conditioning to engine_model
  always_comb begin
    brake_d    = db_q[K_BRK];
    throttle_d = db_q[K_THR] & ~db_q[K_BRK] & ~shifting & ~bus.overload;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      db_prev_q  <= '0;
      for (int k = 0; k < KEY_N; k++) begin
        db_cnt_q[k] <= '0;
      end
      state_q    <= READY;
      gear_q     <= '0;
      tick_cnt_q <= '0;
      denied_q   <= 1'b0;
      throttle_q <= 1'b0;
      brake_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
      db_prev_q  <= db_prev_d;
      for (int k = 0; k < KEY_N; k++) begin
        db_cnt_q[k] <= db_cnt_d[k];
      end
      state_q    <= state_d;
      gear_q     <= gear_d;
      tick_cnt_q <= tick_cnt_d;
      denied_q   <= denied_d;
      throttle_q <= throttle_d;
      brake_q    <= brake_d;
    end
  end

  assign bus.throttle     = throttle_q;
  assign bus.brake        = brake_q;
  assign bus.gear         = gear_q;
  assign bus.shifting     = shifting;
  assign bus.shift_denied = denied_q;

endmodule

// File: tb/tb_drive_input_ctrl.sv
// Bench for drive_input_ctrl: directed and random key sequences checked each clock
// against a sliding-window debounce / gear-rule reference model.
module tb_drive_input_ctrl;
  localparam int D  = 4;
  localparam int ST = 2;
  localparam int MG = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;

  drive_input_ctrl_if bus();

  drive_input_ctrl #(
    .DEBOUNCE_CNT(D),
    .SHIFT_TICKS (ST),
    .MAX_GEAR    (MG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_asserts  = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int den_cnt    = 0;
  int shift_seen = 0;
  int thr_seen   = 0;

  // Reference model state
  bit q_raw [4][$];
  bit m_db [4];
  bit m_db_prev [4];
  int m_gear;
  int m_ticks;
  bit m_busy;
  bit e_thr;
  bit e_brk;
  bit e_den;
  int lim [6] = '{0, 55, 95, 150, 210, 255};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      q_raw[k].delete();
      repeat (D + 2) q_raw[k].push_back(1'b0);
      m_db[k]      = 1'b0;
      m_db_prev[k] = 1'b0;
    end
    m_gear  = 0;
    m_ticks = 0;
    m_busy  = 1'b0;
    e_thr   = 1'b0;
    e_brk   = 1'b0;
    e_den   = 1'b0;
  endtask

  // One clock of the reference: debounced level = raw level two samples back once the
  // last D such samples all agree; gear rules applied to requests seen this clock.
  task automatic model_edge();
    bit raw [4];
    bit up_req, dn_req, den, nb;
    int ng, nt;
    raw[0] = bus.key_throttle;
    raw[1] = bus.key_brake;
    raw[2] = bus.key_up;
    raw[3] = bus.key_down;
    up_req = m_db[2] && !m_db_prev[2];
    dn_req = m_db[3] && !m_db_prev[3];
    e_thr  = m_db[0] && !m_db[1] && !m_busy && !bus.overload;
    e_brk  = m_db[1];
    den = 1'b0;
    ng  = m_gear;
    nb  = m_busy;
    nt  = m_ticks;
    if (!m_busy) begin
      if (up_req && dn_req) begin
        den = 1'b1;
      end else if (up_req) begin
        if (m_gear == MG) den = 1'b1;
        else begin
          ng = m_gear + 1; nb = 1'b1; nt = ST;
        end
      end else if (dn_req) begin
        if (m_gear == 0) den = 1'b1;
        else if (m_gear - 1 != 0 && int'(bus.speed_kmh) > lim[m_gear-1]) den = 1'b1;
        else begin
          ng = m_gear - 1; nb = 1'b1; nt = ST;
        end
      end
    end else begin
      if (up_req || dn_req) den = 1'b1;
      if (m_ticks == 0) nb = 1'b0;
      else if (bus.tick_10hz) nt = m_ticks - 1;
    end
    e_den   = den;
    m_gear  = ng;
    m_busy  = nb;
    m_ticks = nt;
    for (int k = 0; k < 4; k++) begin
      int n;
      bit v;
      bit same;
      q_raw[k].push_back(raw[k]);
      if (q_raw[k].size() > D + 2) void'(q_raw[k].pop_front());
      n    = q_raw[k].size();
      v    = q_raw[k][n-3];
      same = 1'b1;
      for (int i = 0; i < D; i++) begin
        if (q_raw[k][n-3-i] != v) same = 1'b0;
      end
      m_db_prev[k] = m_db[k];
      if (same) m_db[k] = v;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("gear", bus.gear, m_gear);
    chk("shifting", bus.shifting, m_busy);
    chk("throttle", bus.throttle, e_thr);
    chk("brake", bus.brake, e_brk);
    chk("shift_denied", bus.shift_denied, e_den);
    if (bus.shift_denied === 1'b1) den_cnt++;
    if (bus.shifting === 1'b1) shift_seen++;
    if (bus.throttle === 1'b1) thr_seen++;
    bus.tick_10hz = (cyc % 5 == 4);
  endtask

  // mask bits: [0] throttle, [1] brake, [2] up, [3] down
  task automatic press(input logic [3:0] mask, input int hold);
    den_cnt = 0; shift_seen = 0; thr_seen = 0;
    if (mask[0]) bus.key_throttle = 1'b1;
    if (mask[1]) bus.key_brake    = 1'b1;
    if (mask[2]) bus.key_up       = 1'b1;
    if (mask[3]) bus.key_down     = 1'b1;
    repeat (hold) step();
    if (mask[0]) bus.key_throttle = 1'b0;
    if (mask[1]) bus.key_brake    = 1'b0;
    if (mask[2]) bus.key_up       = 1'b0;
    if (mask[3]) bus.key_down     = 1'b0;
    repeat (D + 3) step();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.shifting === 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("idle_wait", bus.shifting, 1'b0);
  endtask

  task automatic goto_gear(input int target);
    int n = 0;
    bus.speed_kmh = '0;
    while (m_gear != target && n < 12) begin
      if (m_gear < target) press(4'b0100, 8);
      else press(4'b1000, 8);
      wait_idle();
      n++;
    end
    chk("goto_gear", bus.gear, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int n;
    bus.tick_10hz    = 1'b0;
    bus.key_throttle = 1'b0;
    bus.key_brake    = 1'b0;
    bus.key_up       = 1'b0;
    bus.key_down     = 1'b0;
    bus.speed_kmh    = '0;
    bus.overload     = 1'b0;
    model_reset();

    // Reset state, before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_gear", bus.gear, 0);
    chk("rst_shifting", bus.shifting, 0);
    chk("rst_throttle", bus.throttle, 0);
    chk("rst_brake", bus.brake, 0);
    chk("rst_denied", bus.shift_denied, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (3) step();

    // Debounce: short glitch never passes, a 10-clk hold gives 10 clks of throttle
    press(4'b0001, $urandom_range(1, D - 1));
    chk("glitch_throttle_cycles", thr_seen, 0);
    press(4'b0001, 10);
    chk("hold_throttle_cycles", thr_seen, 10);

    // Upshift chain 0..6, then denied at the top
    for (int i = 1; i <= 7; i++) begin
      press(4'b0100, 8 + $urandom_range(0, 4));
      wait_idle();
      chk("chain_gear", bus.gear, (i < 7) ? i : 6);
      chk("chain_denied", den_cnt, (i < 7) ? 0 : 1);
      chk("chain_shifting", shift_seen != 0, i < 7);
    end

    // Over-rev protection
    goto_gear(3);
    bus.speed_kmh = 9'd120;
    press(4'b1000, 8);
    chk("overrev_denied", den_cnt, 1);
    chk("overrev_gear", bus.gear, 3);
    bus.speed_kmh = 9'd90;
    press(4'b1000, 8);
    chk("down_ok_denied", den_cnt, 0);
    chk("down_ok_gear", bus.gear, 2);
    chk("down_ok_shifting", shift_seen != 0, 1);
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      bus.speed_kmh = 9'($urandom_range(0, 300));
      press($urandom_range(0, 1) ? 4'b0100 : 4'b1000, 8);
      wait_idle();
    end

    // Clutch and throttle masking
    goto_gear(2);
    bus.key_throttle = 1'b1;
    repeat (10) step();
    chk("thr_held", bus.throttle, 1);
    press(4'b0100, 8);
    wait_idle();
    repeat (2) step();
    chk("thr_after_clutch", bus.throttle, 1);
    chk("clutch_gear", bus.gear, 3);
    bus.key_brake = 1'b1;
    repeat (8) step();
    chk("brake_masks_thr", bus.throttle, 0);
    chk("brake_out", bus.brake, 1);
    bus.key_brake = 1'b0;
    repeat (8) step();
    chk("brake_release_thr", bus.throttle, 1);
    bus.overload = 1'b1;
    repeat (2) step();
    chk("overload_masks_thr", bus.throttle, 0);
    bus.overload = 1'b0;
    repeat (2) step();
    chk("overload_release_thr", bus.throttle, 1);
    bus.key_throttle = 1'b0;
    repeat (D + 4) step();

    // Conflicting requests and requests during SHIFT
    g0 = m_gear;
    press(4'b1100, 8);
    chk("conflict_denied", den_cnt, 1);
    chk("conflict_gear", bus.gear, g0);
    den_cnt = 0;
    bus.key_up = 1'b1;
    repeat (2) step();
    bus.key_down = 1'b1;
    repeat (10) step();
    bus.key_up = 1'b0;
    bus.key_down = 1'b0;
    repeat (D + 3) step();
    wait_idle();
    chk("in_shift_denied", den_cnt, 1);
    chk("in_shift_gear", bus.gear, g0 + 1);

    // Random key/speed/overload traffic
    for (int i = 0; i < 40; i++) begin
      bus.key_throttle = 1'($urandom_range(0, 1));
      bus.key_brake    = ($urandom_range(0, 3) == 0);
      bus.key_up       = 1'($urandom_range(0, 1));
      bus.key_down     = 1'($urandom_range(0, 1));
      bus.speed_kmh    = 9'($urandom_range(0, 300));
      bus.overload     = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 12)) step();
    end
    bus.key_throttle = 1'b0;
    bus.key_brake    = 1'b0;
    bus.key_up       = 1'b0;
    bus.key_down     = 1'b0;
    bus.overload     = 1'b0;
    repeat (D + 4) step();
    wait_idle();

    // Asynchronous reset in the middle of a shift into gear 4
    goto_gear(3);
    bus.key_up = 1'b1;
    n = 0;
    while (bus.shifting !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("mid_shift_entered", bus.shifting, 1);
    chk("mid_shift_gear", bus.gear, 4);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_gear", bus.gear, 0);
    chk("async_rst_shifting", bus.shifting, 0);
    chk("async_rst_denied", bus.shift_denied, 0);
    bus.key_up = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (D + 6) step();
    chk("post_rst_gear", bus.gear, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/drive_input_ctrl.md
Name: drive_input_ctrl

Overview:
Front-end stage feeding engine_model. It conditions the raw board keys (throttle, brake, shift-up, shift-down) with synchronisers and debouncers, and owns the current gear through a shift state machine. That state machine applies a clutch interval and refuses any downshift that would over-rev the engine. It drives engine_model's throttle/brake/gear inputs and consumes speed_kmh and overload back from it, using overload to cut throttle.

Parameters:
DEBOUNCE_CNT, 50000, consecutive clk cycles a synchronised key must hold a new level before the debounced level changes (1 ms at 50 MHz); legal range 1..65535
SHIFT_TICKS, 3, tick_10hz pulses the clutch interval lasts after an accepted shift; 0 allowed
MAX_GEAR, 6, highest selectable gear

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tick_10hz  in  1  one-clk strobe at 10 Hz (same strobe engine_model uses)
key_throttle  in  1  raw asynchronous key, 1 = pressed
key_brake  in  1  raw asynchronous key, 1 = pressed
key_up  in  1  raw shift-up key
key_down  in  1  raw shift-down key
speed_kmh  in  9  current speed from engine_model
overload  in  1  rpm >= overload threshold, from engine_model
throttle  out  1  to engine_model
brake  out  1  to engine_model
gear  out  3  0 = neutral, 1..MAX_GEAR
shifting  out  1  clutch interval active
shift_denied  out  1  one-clk pulse when a shift request is rejected

Behaviour:
- Reset (async, immediate): gear=0, throttle=0, brake=0, shifting=0, shift_denied=0. FSM=READY. Debounced levels=0. Debounce counters=0. Synchronisers=0. Mid-operation reset aborts any shift; the gear stays 0 after release.
- Per key: 2-FF synchroniser, then debouncer. Counter clears whenever the sync level equals the debounced level. Otherwise it increments; when it reaches DEBOUNCE_CNT-1 the debounced level flips and the counter clears. A steady press appears DEBOUNCE_CNT+2 clks after the raw edge. Glitches shorter than DEBOUNCE_CNT clks are never passed.
- Edge detect: up_req/down_req = debounced rising edge, one clk wide. Holding a key produces exactly one request.
- brake = debounced brake, registered (1 clk after the debounced level). It is never masked.
- throttle = debounced throttle AND NOT brake_db AND NOT shifting AND NOT overload, registered.
- Downshift speed limits into target gear T: T=1: 55, T=2: 95, T=3: 150, T=4: 210, T=5: 255 km/h. T=0 (neutral) has no limit.
- FSM states READY and SHIFT. shifting = (state==SHIFT).
- READY, up_req only:
  - gear==MAX_GEAR -> shift_denied pulse, gear unchanged.
  - else gear<=gear+1 and go to SHIFT with cnt<=SHIFT_TICKS.
- READY, down_req only:
  - gear==0 -> denied.
  - target=gear-1; target!=0 and speed_kmh > limit(target) -> denied.
  - else gear<=target and go to SHIFT with cnt<=SHIFT_TICKS.
- READY, up_req and down_req in the same clk -> denied, gear unchanged.
- SHIFT:
  - Any up_req/down_req -> denied; the request is not queued.
  - If cnt==0, return to READY next clk.
  - Else on tick_10hz cnt<=cnt-1; leave SHIFT on the clk after cnt reaches 0.
- Gear changes on the clk after the request edge and is stable throughout SHIFT.
- shift_denied is high for exactly one clk per rejected request. No pulse on accepted requests.
- speed_kmh is sampled in the same clk as the request edge.

Test Plan:
DEBOUNCE_CNT=4, SHIFT_TICKS=2 for all runs.
1. Debounce: key_throttle glitch of 2 clks -> throttle stays 0. Hold 10 clks -> throttle=1 about 7 clks after the raw edge; release -> throttle=0 after the same delay.
2. Upshift chain: gear 0, speed 0; press key_up 7 times, each release waiting out SHIFT. Gear goes 1..6; shifting high 2 ticks each time; the 7th press gives shift_denied pulse, gear stays 6.
3. Over-rev protection: gear=3, speed_kmh=120, press key_down -> shift_denied=1 for 1 clk, gear=3. With speed_kmh=90 -> gear=2, shifting=1.
4. Clutch and masking: throttle held, accept upshift -> throttle=0 during SHIFT, back to 1 after the 2nd tick_10hz. Brake held -> throttle=0 while brake=1. overload=1 -> throttle=0.
5. Conflict: key_up and key_down debounced in the same clk -> one shift_denied pulse, gear unchanged. key_up during SHIFT -> denied, no queued shift.
6. Reset mid-shift: rst asserted while in SHIFT at gear 4 -> gear=0, shifting=0 immediately, before any clk edge.
